// File: rtl/hazard_scoreboard.sv
// Scoreboard issue controller: per-register pending-write counters, multiplier
// occupancy and branch flush window. Optional SCOREBOARD_WB_BYPASS_EN lets a consumer issue in its producer's retire cycle.
module hazard_scoreboard #(
  parameter int MAX_PEND  = 3,
  parameter int MUL_LAT   = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid_inst,
  input  logic [4:0] id_ra_idx,
  input  logic [4:0] id_rb_idx,
  input  logic       id_reg_wr,
  input  logic [4:0] id_dest_idx,
  input  logic       id_is_mul,
  input  logic       ex_take_branch,
  input  logic       wb_valid_inst,
  input  logic       wb_reg_wr,
  input  logic [4:0] wb_dest_idx,
  output logic       id_stall,
  output logic       id_issue,
  output logic       pipe_flush,
  output logic       mul_busy,
  output logic       pending_any,
  output logic       sb_err,
  output logic       flush_state
);

  localparam int CW = $clog2(MAX_PEND + 1);
  localparam int MW = $clog2(MUL_LAT + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [CW-1:0] PEND_MAX   = CW'(MAX_PEND);
  localparam logic [CW-1:0] PEND_ONE   = CW'(1);
  localparam logic [MW-1:0] MUL_LOAD   = MW'(MUL_LAT - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);
  localparam logic [FW-1:0] FCNT_ONE   = FW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  flush_state_t state, state_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic [MW-1:0] mcnt;
  logic [CW-1:0] pend     [32];
  logic [CW-1:0] pend_nxt [32];
  logic [31:0]   inc_vec;
  logic [31:0]   dec_vec;
  logic          err_set;
  logic          wb_dec;
  logic          ra_haz, rb_haz, sat_haz, mul_haz, any_haz;

  assign wb_dec = wb_valid_inst && wb_reg_wr && (wb_dest_idx != 5'd0);

  // Source hazards; x0 reads never hazard.
  always_comb begin
    ra_haz = (id_ra_idx != 5'd0) && (pend[id_ra_idx] != '0);
    rb_haz = (id_rb_idx != 5'd0) && (pend[id_rb_idx] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_dec && (wb_dest_idx == id_ra_idx) && (pend[id_ra_idx] == PEND_ONE))
      ra_haz = 1'b0;
    if (wb_dec && (wb_dest_idx == id_rb_idx) && (pend[id_rb_idx] == PEND_ONE))
      rb_haz = 1'b0;
`endif
    sat_haz = id_reg_wr && (id_dest_idx != 5'd0) && (pend[id_dest_idx] == PEND_MAX);
    mul_haz = id_is_mul && mul_busy;
    any_haz = ra_haz || rb_haz || sat_haz || mul_haz;
  end

  assign mul_busy = (mcnt != '0);
  assign id_stall = id_valid_inst && !pipe_flush && any_haz;
  assign id_issue = id_valid_inst && !pipe_flush && !any_haz;

  // Bit 0 is masked so x0 is never tracked.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (id_issue && id_reg_wr)
      inc_vec = (32'd1 << id_dest_idx) & ~32'd1;
    if (wb_dec)
      dec_vec = (32'd1 << wb_dest_idx) & ~32'd1;
  end

  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < 32; r++) begin
      pend_nxt[r] = pend[r];
      case ({inc_vec[r], dec_vec[r]})
        2'b10: pend_nxt[r] = pend[r] + PEND_ONE;
        2'b01: begin
          if (pend[r] == '0) err_set = 1'b1;
          else pend_nxt[r] = pend[r] - PEND_ONE;
        end
        default: pend_nxt[r] = pend[r];
      endcase
    end
  end

  always_comb begin
    pending_any = 1'b0;
    for (int r = 1; r < 32; r++)
      if (pend[r] != '0) pending_any = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) pend[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) pend[r] <= pend_nxt[r];
      if (err_set) sb_err <= 1'b1;
    end
  end

  // Multiplier occupancy: the issue cycle itself is not counted as busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mcnt <= '0;
    else if (id_issue && id_is_mul)
      mcnt <= MUL_LOAD;
    else if (mcnt != '0)
      mcnt <= mcnt - MW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // fcnt holds the FLUSH-state cycles still to run, counting the current one.
  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    pipe_flush  = ex_take_branch || (state == FLUSH);
    flush_state = (state == FLUSH);
    case (state)
      IDLE: begin
        if (ex_take_branch && (FLUSH_CYC > 1)) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (ex_take_branch) begin
          fcnt_nxt = FLUSH_LOAD;
        end else if ((fcnt == FCNT_ONE) || (fcnt == '0)) begin
          state_nxt = IDLE;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt = fcnt - FCNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        fcnt_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic compared with a counter/array reference model.
module tb_hazard_scoreboard;

  localparam int MAX_PEND  = 3;
  localparam int MUL_LAT   = 4;
  localparam int FLUSH_CYC = 2;

  logic       clk;
  logic       rst;
  logic       id_valid_inst;
  logic [4:0] id_ra_idx, id_rb_idx, id_dest_idx;
  logic       id_reg_wr, id_is_mul, ex_take_branch;
  logic       wb_valid_inst, wb_reg_wr;
  logic [4:0] wb_dest_idx;
  logic       id_stall, id_issue, pipe_flush, mul_busy, pending_any, sb_err, flush_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int m_pend [32];
  int m_mul;
  int m_flush;
  bit m_err;

  hazard_scoreboard #(
    .MAX_PEND(MAX_PEND), .MUL_LAT(MUL_LAT), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid_inst(id_valid_inst), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
    .id_reg_wr(id_reg_wr), .id_dest_idx(id_dest_idx), .id_is_mul(id_is_mul),
    .ex_take_branch(ex_take_branch),
    .wb_valid_inst(wb_valid_inst), .wb_reg_wr(wb_reg_wr), .wb_dest_idx(wb_dest_idx),
    .id_stall(id_stall), .id_issue(id_issue), .pipe_flush(pipe_flush),
    .mul_busy(mul_busy), .pending_any(pending_any), .sb_err(sb_err),
    .flush_state(flush_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_id(input bit v, input int ra, input int rb, input bit wr,
                        input int dest, input bit mul);
    id_valid_inst = v;
    id_ra_idx     = 5'(ra);
    id_rb_idx     = 5'(rb);
    id_reg_wr     = wr;
    id_dest_idx   = 5'(dest);
    id_is_mul     = mul;
  endtask

  task automatic set_wb(input bit v, input int dest);
    wb_valid_inst = v;
    wb_reg_wr     = v;
    wb_dest_idx   = 5'(dest);
  endtask

  task automatic idle_inputs();
    set_id(0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    ex_take_branch = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    m_mul   = 0;
    m_flush = 0;
    m_err   = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_src_haz(input logic [4:0] idx);
    if (idx == 5'd0 || m_pend[idx] == 0) return 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (m_pend[idx] == 1 && wb_valid_inst && wb_reg_wr && wb_dest_idx == idx) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // {stall, issue, flush, mul_busy, pending_any, sb_err}
  function automatic logic [5:0] model_expect();
    bit fl, hz, pa;
    fl = ex_take_branch || (m_flush > 0);
    hz = m_src_haz(id_ra_idx) || m_src_haz(id_rb_idx) ||
         (id_reg_wr && id_dest_idx != 5'd0 && m_pend[id_dest_idx] == MAX_PEND) ||
         (id_is_mul && m_mul > 0);
    pa = 1'b0;
    for (int r = 1; r < 32; r++) if (m_pend[r] > 0) pa = 1'b1;
    return {id_valid_inst && !fl && hz, id_valid_inst && !fl && !hz, fl, m_mul > 0, pa, m_err};
  endfunction

  // Advance model with the current inputs, then cross the clock edge.
  task automatic tick();
    logic [5:0] e;
    e = model_expect();
    if (e[4] && id_reg_wr && id_dest_idx != 5'd0) m_pend[id_dest_idx]++;
    if (wb_valid_inst && wb_reg_wr && wb_dest_idx != 5'd0) begin
      if (m_pend[wb_dest_idx] == 0) m_err = 1'b1;
      else m_pend[wb_dest_idx]--;
    end
    if (e[4] && id_is_mul) m_mul = MUL_LAT - 1;
    else if (m_mul > 0) m_mul--;
    if (ex_take_branch) m_flush = FLUSH_CYC - 1;
    else if (m_flush > 0) m_flush--;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    set_id(1, 3, 4, 1, 8, 1);
    #1;
    tests_run++;
    if ({id_stall, id_issue, pipe_flush, mul_busy, pending_any, sb_err, flush_state} !== 7'b0100000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0100000",
               {id_stall, id_issue, pipe_flush, mul_busy, pending_any, sb_err, flush_state});
    end
    ex_take_branch = 1'b1;
    #1;
    tests_run++;
    if ({pipe_flush, id_issue} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_branch: got flush/issue=%b expected 10", {pipe_flush, id_issue});
    end
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_raw();
    set_id(1, 1, 2, 1, 5, 0);
    #1;
    tests_run++;
    if (id_issue !== 1'b1) begin
      tests_failed++; $display("FAIL raw_producer: got issue=%b expected 1", id_issue);
    end
    tick();
    set_id(1, 5, 1, 1, 6, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if ({id_stall, id_issue} !== 2'b10) begin
        tests_failed++; $display("FAIL raw_stall: got stall/issue=%b expected 10", {id_stall, id_issue});
      end
      tick();
    end
    set_wb(1, 5);
    #1;
    tests_run++;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if ({id_stall, id_issue} !== 2'b01) begin
      tests_failed++; $display("FAIL raw_retire_cycle: got stall/issue=%b expected 01", {id_stall, id_issue});
    end
    tick();
    set_wb(0, 0);
`else
    if ({id_stall, id_issue} !== 2'b10) begin
      tests_failed++; $display("FAIL raw_retire_cycle: got stall/issue=%b expected 10", {id_stall, id_issue});
    end
    tick();
    set_wb(0, 0);
    #1;
    tests_run++;
    if ({id_stall, id_issue} !== 2'b01) begin
      tests_failed++; $display("FAIL raw_after_retire: got stall/issue=%b expected 01", {id_stall, id_issue});
    end
    tick();
`endif
    set_id(0, 0, 0, 0, 0, 0);
    set_wb(1, 6);
    tick();
    set_wb(0, 0);
    #1;
    tests_run++;
    if ({pending_any, sb_err} !== 2'b00) begin
      tests_failed++; $display("FAIL raw_drain: got pending/err=%b expected 00", {pending_any, sb_err});
    end
  endtask

  task automatic test_saturation();
    set_id(1, 0, 0, 1, 7, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (id_issue !== 1'b1) begin
        tests_failed++; $display("FAIL sat_fill%0d: got issue=%b expected 1", i, id_issue);
      end
      tick();
    end
    #1;
    tests_run++;
    if ({id_stall, id_issue, pending_any} !== 3'b101) begin
      tests_failed++; $display("FAIL sat_fourth: got stall/issue/pend=%b expected 101", {id_stall, id_issue, pending_any});
    end
    tick();
    set_wb(1, 7);
    #1;
    tests_run++;
    if ({id_stall, id_issue} !== 2'b10) begin
      tests_failed++; $display("FAIL sat_retire_cycle: got stall/issue=%b expected 10", {id_stall, id_issue});
    end
    tick();
    set_wb(0, 0);
    #1;
    tests_run++;
    if ({id_stall, id_issue} !== 2'b01) begin
      tests_failed++; $display("FAIL sat_release: got stall/issue=%b expected 01", {id_stall, id_issue});
    end
    tick();
    set_id(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_wb(1, 7);
      tick();
    end
    set_wb(0, 0);
    #1;
    tests_run++;
    if ({pending_any, sb_err} !== 2'b00) begin
      tests_failed++; $display("FAIL sat_drain: got pending/err=%b expected 00", {pending_any, sb_err});
    end
  endtask

  task automatic test_mul();
    int busy_cnt;
    set_id(1, 0, 0, 0, 0, 1);
    #1;
    tests_run++;
    if ({id_issue, mul_busy} !== 2'b10) begin
      tests_failed++; $display("FAIL mul_first: got issue/busy=%b expected 10", {id_issue, mul_busy});
    end
    tick();
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      #1;
      tests_run++;
      if ({id_stall, id_issue, mul_busy} !== 3'b101) begin
        tests_failed++; $display("FAIL mul_stall%0d: got stall/issue/busy=%b expected 101", i, {id_stall, id_issue, mul_busy});
      end
      tick();
    end
    #1;
    tests_run++;
    if ({id_stall, id_issue, mul_busy} !== 3'b010) begin
      tests_failed++; $display("FAIL mul_second: got stall/issue/busy=%b expected 010", {id_stall, id_issue, mul_busy});
    end
    tick();
    set_id(0, 0, 0, 0, 0, 0);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mul_busy === 1'b1) busy_cnt++;
      tick();
    end
    tests_run++;
    if (busy_cnt != MUL_LAT - 1) begin
      tests_failed++; $display("FAIL mul_busy_len: got %0d cycles expected %0d", busy_cnt, MUL_LAT - 1);
    end
  endtask

  task automatic test_flush();
    set_id(1, 0, 0, 1, 11, 0);
    ex_take_branch = 1'b1;
    #1;
    tests_run++;
    if ({pipe_flush, id_issue, id_stall, flush_state} !== 4'b1000) begin
      tests_failed++; $display("FAIL flush_n: got flush/issue/stall/state=%b expected 1000", {pipe_flush, id_issue, id_stall, flush_state});
    end
    tick();
    ex_take_branch = 1'b0;
    #1;
    tests_run++;
    if ({pipe_flush, id_issue, flush_state, pending_any} !== 4'b1010) begin
      tests_failed++; $display("FAIL flush_n1: got flush/issue/state/pend=%b expected 1010", {pipe_flush, id_issue, flush_state, pending_any});
    end
    tick();
    #1;
    tests_run++;
    if ({pipe_flush, id_issue, flush_state, pending_any} !== 4'b0100) begin
      tests_failed++; $display("FAIL flush_end: got flush/issue/state/pend=%b expected 0100", {pipe_flush, id_issue, flush_state, pending_any});
    end
    set_id(1, 0, 0, 0, 0, 0);
    ex_take_branch = 1'b1;
    tick();
    #1;
    tests_run++;
    if ({pipe_flush, id_issue} !== 2'b10) begin
      tests_failed++; $display("FAIL flush_rebranch: got flush/issue=%b expected 10", {pipe_flush, id_issue});
    end
    tick();
    ex_take_branch = 1'b0;
    #1;
    tests_run++;
    if ({pipe_flush, id_issue} !== 2'b10) begin
      tests_failed++; $display("FAIL flush_extend: got flush/issue=%b expected 10", {pipe_flush, id_issue});
    end
    tick();
    #1;
    tests_run++;
    if ({pipe_flush, id_issue, flush_state} !== 3'b010) begin
      tests_failed++; $display("FAIL flush_extend_end: got flush/issue/state=%b expected 010", {pipe_flush, id_issue, flush_state});
    end
    set_id(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_err();
    set_wb(1, 9);
    #1;
    tests_run++;
    if (sb_err !== 1'b0) begin
      tests_failed++; $display("FAIL err_before: got sb_err=%b expected 0", sb_err);
    end
    tick();
    set_wb(0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({sb_err, pending_any} !== 2'b10) begin
        tests_failed++; $display("FAIL err_sticky%0d: got err/pend=%b expected 10", i, {sb_err, pending_any});
      end
      tick();
    end
    set_id(1, 0, 0, 1, 3, 0);
    tick();
    set_wb(1, 3);
    #1;
    tests_run++;
    if (id_issue !== 1'b1) begin
      tests_failed++; $display("FAIL same_cycle_issue: got issue=%b expected 1", id_issue);
    end
    tick();
    set_wb(0, 0);
    set_id(1, 3, 0, 0, 0, 0);
    #1;
    tests_run++;
    if ({id_stall, pending_any} !== 2'b11) begin
      tests_failed++; $display("FAIL same_cycle_kept: got stall/pend=%b expected 11", {id_stall, pending_any});
    end
    set_wb(1, 3);
    tick();
    set_wb(0, 0);
    #1;
    tests_run++;
    if ({id_issue, pending_any, sb_err} !== 3'b101) begin
      tests_failed++; $display("FAIL same_cycle_single: got issue/pend/err=%b expected 101", {id_issue, pending_any, sb_err});
    end
    set_id(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    set_id(1, 0, 0, 1, 4, 0);
    tick();
    set_id(1, 0, 0, 1, 4, 1);
    tick();
    set_id(1, 4, 0, 0, 0, 1);
    #1;
    tests_run++;
    if ({id_stall, mul_busy, pending_any} !== 3'b111) begin
      tests_failed++; $display("FAIL rmid_pre: got stall/busy/pend=%b expected 111", {id_stall, mul_busy, pending_any});
    end
    #1 rst = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({id_stall, id_issue, pipe_flush, mul_busy, pending_any, sb_err} !== 6'b010000) begin
      tests_failed++; $display("FAIL rmid_outputs: got %b expected 010000",
                               {id_stall, id_issue, pipe_flush, mul_busy, pending_any, sb_err});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0);
    ex_take_branch = 1'b1;
    tick();
    ex_take_branch = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({pipe_flush, flush_state} !== 2'b00) begin
      tests_failed++; $display("FAIL rmid_flush: got flush/state=%b expected 00", {pipe_flush, flush_state});
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] e;
    int r;
    for (int n = 0; n < 600; n++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 4) == 0);
      ex_take_branch = ($urandom_range(0, 11) == 0);
      set_wb(0, 0);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 7);
        if (m_pend[r] > 0 || $urandom_range(0, 63) == 0) begin
          set_wb(1, r);
          wb_reg_wr = ($urandom_range(0, 7) != 0);
        end
      end
      #1;
      e = model_expect();
      tests_run++;
      if ({id_stall, id_issue, pipe_flush, mul_busy, pending_any, sb_err} !== e) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: got stall/issue/flush/busy/pend/err=%b expected %b",
                 n, {id_stall, id_issue, pipe_flush, mul_busy, pending_any, sb_err}, e);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_raw();
    test_saturation();
    test_mul();
    test_flush();
    test_err();
    test_reset_mid();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
